// File: rtl/btn_debounce_repeat.sv
// Per-channel push-button conditioning: 2-flop sync, debounce, and press/auto-repeat
// pulse generation for the counter's increment path.
module btn_debounce_repeat #(
  parameter int DIGITS          = 3,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 500000,
  parameter int REPEAT_CYCLES   = 100000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIGITS-1:0] btn_n_in,
  input  logic              repeat_en,
  output logic [DIGITS-1:0] btn_level,
  output logic [DIGITS-1:0] btn_pulse,
  output logic              btn_held
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [DIGITS-1:0] rep_flag;

  // rep_flag is a flop per channel, so btn_held has no path from any input.
  assign btn_held = |rep_flag;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_ch
      logic             sync_a;
      logic             sync_b;
      logic             s;
      logic             level;
      logic             level_next;
      logic             differ;
      logic             settle;
      logic             pulse;
      logic [CNT_W-1:0] dcnt;
      logic [CNT_W-1:0] tcnt;
      state_t           state;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_a <= 1'b1;
          sync_b <= 1'b1;
        end else begin
          sync_a <= btn_n_in[gi];
          sync_b <= sync_a;
        end
      end

      assign s          = ~sync_b;
      assign differ     = s ^ level;
      assign settle     = differ && (dcnt == D_LAST);
      assign level_next = settle ? ~level : level;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          level <= 1'b0;
          dcnt  <= '0;
        end else if (settle) begin
          level <= ~level;
          dcnt  <= '0;
        end else if (differ) begin
          dcnt <= dcnt + 1'b1;
        end else begin
          dcnt <= '0;
        end
      end

      // The FSM looks at level_next so the press pulse lines up with the
      // btn_level rise and a release cancels any repeat due on that edge.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state         <= IDLE;
          tcnt          <= '0;
          pulse         <= 1'b0;
          rep_flag[gi]  <= 1'b0;
        end else begin
          pulse <= 1'b0;
          if (!level_next) begin
            state        <= IDLE;
            tcnt         <= '0;
            rep_flag[gi] <= 1'b0;
          end else begin
            case (state)
              IDLE: begin
                if (!level) begin
                  pulse <= 1'b1;
                  tcnt  <= '0;
                  state <= HOLD;
                end
              end
              HOLD: begin
                if (tcnt == H_LAST) begin
                  if (repeat_en) begin
                    pulse        <= 1'b1;
                    tcnt         <= '0;
                    state        <= REPEAT;
                    rep_flag[gi] <= 1'b1;
                  end
                end else begin
                  tcnt <= tcnt + 1'b1;
                end
              end
              REPEAT: begin
                if (!repeat_en) begin
                  // Parking at the saturated hold count silences the channel.
                  state        <= HOLD;
                  tcnt         <= H_LAST;
                  rep_flag[gi] <= 1'b0;
                end else if (tcnt == R_LAST) begin
                  pulse <= 1'b1;
                  tcnt  <= '0;
                end else begin
                  tcnt <= tcnt + 1'b1;
                end
              end
              default: begin
                state        <= IDLE;
                tcnt         <= '0;
                rep_flag[gi] <= 1'b0;
              end
            endcase
          end
        end
      end

      assign btn_level[gi] = level;
      assign btn_pulse[gi] = pulse;
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Directed bench for btn_debounce_repeat with short debounce/hold/repeat times.
module tb_btn_debounce_repeat;

  localparam int DIGITS = 3;

  logic              clk;
  logic              rst_n;
  logic [DIGITS-1:0] btn_n_in;
  logic              repeat_en;
  logic [DIGITS-1:0] btn_level;
  logic [DIGITS-1:0] btn_pulse;
  logic              btn_held;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt;
  int pulse_at;

  btn_debounce_repeat #(
    .DIGITS(3),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_n_in(btn_n_in),
    .repeat_en(repeat_en),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .btn_held(btn_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic release_all();
    btn_n_in = 3'b111;
    tick(12);
    check("release_level", 32'(btn_level), 32'(3'b000));
    check("release_held", 32'(btn_held), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    btn_n_in  = 3'b111;
    repeat_en = 1'b0;
    tick(3);
    check("reset_level", 32'(btn_level), 32'(3'b000));
    check("reset_pulse", 32'(btn_pulse), 32'(3'b000));
    check("reset_held", 32'(btn_held), 32'd0);
    rst_n = 1'b1;
    tick(4);
    check("idle_level", 32'(btn_level), 32'(3'b000));

    // 1: clean press on ch0, no repeat
    btn_n_in = 3'b110;
    tick(5);
    check("t1_pre_pulse", 32'(btn_pulse), 32'(3'b000));
    check("t1_pre_level", 32'(btn_level), 32'(3'b000));
    tick(1);
    check("t1_pulse", 32'(btn_pulse), 32'(3'b001));
    check("t1_level", 32'(btn_level), 32'(3'b001));
    pulse_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (btn_pulse[0]) pulse_cnt++;
    end
    check("t1_no_more_pulses", 32'(pulse_cnt), 32'd0);
    check("t1_held", 32'(btn_held), 32'd0);
    btn_n_in = 3'b111;
    pulse_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (btn_pulse[0]) pulse_cnt++;
    end
    check("t1_release_level", 32'(btn_level), 32'(3'b000));
    check("t1_release_pulse", 32'(pulse_cnt), 32'd0);
    $display("phase 1 clean press done");
    release_all();

    // 2: bouncing press on ch1
    begin
      logic [8:0] seq;
      seq = 9'b000010010;  // bit k is the ch1 pin level applied before edge k
      pulse_cnt = 0;
      pulse_at  = -1;
      for (int k = 0; k < 30; k++) begin
        btn_n_in = {1'b1, (k < 9) ? seq[k] : 1'b0, 1'b1};
        tick(1);
        if (btn_pulse[1]) begin
          pulse_cnt++;
          if (pulse_at < 0) pulse_at = k;
        end
      end
    end
    check("t2_pulse_count", 32'(pulse_cnt), 32'd1);
    check("t2_pulse_time", 32'(pulse_at), 32'd10);
    check("t2_level", 32'(btn_level), 32'(3'b010));
    $display("phase 2 bounce done");
    release_all();

    // 3: auto-repeat on ch2
    repeat_en = 1'b1;
    btn_n_in  = 3'b011;
    tick(5);
    check("t3_pre_pulse", 32'(btn_pulse), 32'(3'b000));
    for (int off = 0; off < 25; off++) begin
      tick(1);
      check($sformatf("t3_pulse_off%0d", off), 32'(btn_pulse),
            (off == 0 || (off >= 10 && (off - 10) % 3 == 0)) ? 32'(3'b100) : 32'(3'b000));
      check($sformatf("t3_held_off%0d", off), 32'(btn_held), (off >= 10) ? 32'd1 : 32'd0);
    end
    btn_n_in = 3'b111;
    tick(5);
    check("t3_level_before_fall", 32'(btn_level), 32'(3'b100));
    tick(1);
    check("t3_level_fall", 32'(btn_level), 32'(3'b000));
    check("t3_fall_pulse", 32'(btn_pulse), 32'(3'b000));
    check("t3_fall_held", 32'(btn_held), 32'd0);
    pulse_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (btn_pulse != 3'b000) pulse_cnt++;
    end
    check("t3_after_release_pulses", 32'(pulse_cnt), 32'd0);
    $display("phase 3 auto-repeat done");
    release_all();

    // 4: simultaneous press, then repeat disabled during REPEAT
    btn_n_in = 3'b000;
    tick(5);
    check("t4_pre_pulse", 32'(btn_pulse), 32'(3'b000));
    tick(1);
    check("t4_pulse", 32'(btn_pulse), 32'(3'b111));
    tick(1);
    check("t4_pulse_width", 32'(btn_pulse), 32'(3'b000));
    tick(9);
    check("t4_repeat_pulse", 32'(btn_pulse), 32'(3'b111));
    check("t4_held", 32'(btn_held), 32'd1);
    tick(1);
    repeat_en = 1'b0;
    tick(1);
    check("t4_held_drop", 32'(btn_held), 32'd0);
    pulse_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (btn_pulse != 3'b000) pulse_cnt++;
    end
    check("t4_no_pulses", 32'(pulse_cnt), 32'd0);
    check("t4_held_off", 32'(btn_held), 32'd0);
    check("t4_level", 32'(btn_level), 32'(3'b111));
    $display("phase 4 simultaneous done");
    release_all();

    // 5: reset while ch0 is repeating with the button still held
    repeat_en = 1'b1;
    btn_n_in  = 3'b110;
    tick(6);
    check("t5_press_pulse", 32'(btn_pulse), 32'(3'b001));
    tick(11);
    check("t5_in_repeat", 32'(btn_held), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("t5_rst_level", 32'(btn_level), 32'(3'b000));
    check("t5_rst_pulse", 32'(btn_pulse), 32'(3'b000));
    check("t5_rst_held", 32'(btn_held), 32'd0);
    rst_n = 1'b1;
    tick(5);
    check("t5_pre_pulse", 32'(btn_pulse), 32'(3'b000));
    check("t5_pre_level", 32'(btn_level), 32'(3'b000));
    tick(1);
    check("t5_new_pulse", 32'(btn_pulse), 32'(3'b001));
    check("t5_new_level", 32'(btn_level), 32'(3'b001));
    $display("phase 5 reset mid-repeat done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
